md_ctrl: RTL and testbench



---
 rtl/md_defs_pkg.sv | 31 +++
 rtl/md_calc.sv | 54 +++++
 rtl/md_ctrl.sv | 91 +++++++++
 tb/tb_md_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/md_defs_pkg.sv
// Shared definitions for the multiply/divide unit: E-stage md_op encoding,
// sequencer states and default latencies.
package md_defs;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } md_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_start_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_mult_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath producing the {hi,lo} result of a
// latched operation, plus a flag telling the sequencer to keep HI/LO on /0.
module md_calc
  import md_defs::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        hold
);

  logic        signed_div;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] product;

  // Signed division runs on magnitudes so INT_MIN / -1 wraps to INT_MIN with
  // a zero remainder instead of hitting an overflow case.
  always_comb begin
    signed_div = (op == OP_DIV);
    a_mag      = (signed_div && a[31]) ? (32'd0 - a) : a;
    b_mag      = (signed_div && b[31]) ? (32'd0 - b) : b;
    divisor    = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag      = a_mag / divisor;
    r_mag      = a_mag % divisor;
    quot       = (signed_div && (a[31] ^ b[31])) ? (32'd0 - q_mag) : q_mag;
    rem        = (signed_div && a[31]) ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    if (op == OP_MULT) begin
      a_ext = {{32{a[31]}}, a};
      b_ext = {{32{b[31]}}, b};
    end else begin
      a_ext = {32'd0, a};
      b_ext = {32'd0, b};
    end
    product = a_ext * b_ext;
  end

  always_comb begin
    result = is_mult_op(op) ? product : {rem, quot};
    hold   = ((op == OP_DIV) || (op == OP_DIVU)) && (b == 32'd0);
  end

endmodule

// File: rtl/md_ctrl.sv
// E-stage multiply/divide sequencer: owns HI/LO, counts the fixed latency of
// mult/div operations and raises md_stall to hold md-class instructions in D.
module md_ctrl
  import md_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_is_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        md_stall
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_t      state;
  logic [CNT_W-1:0] count;
  logic [2:0]     op_q;
  logic [31:0]    a_q;
  logic [31:0]    b_q;
  logic [63:0]    result;
  logic           hold;
  logic           start;

  md_calc u_calc (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (result),
    .hold   (hold)
  );

  assign start    = (state == ST_IDLE) && is_start_op(md_op);
  assign md_stall = d_is_md & (busy | start);

  // The result lands in HI/LO on the edge that ends the last busy cycle, so
  // no partial value is ever observable while busy is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
      op_q  <= OP_NONE;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q  <= md_op;
            a_q   <= rs_val;
            b_q   <= rt_val;
            count <= is_mult_op(md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            state <= ST_BUSY;
            busy  <= 1'b1;
          end else if (md_op == OP_MTHI) begin
            hi <= rs_val;
          end else if (md_op == OP_MTLO) begin
            lo <= rs_val;
          end
        end
        ST_BUSY: begin
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            if (!hold) begin
              hi <= result[63:32];
              lo <= result[31:0];
            end
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed and random mult/div/mthi/mtlo
// sequences compared against a 64-bit arithmetic model of HI/LO and timing.
module tb_md_ctrl;
  import md_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_is_md;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        md_stall;

  int checks   = 0;
  int failures = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  md_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .d_is_md  (d_is_md),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .md_stall (md_stall)
  );

  always #5 clk = ~clk;

  function automatic int latency(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return 5;
    if (op == 3'd3 || op == 3'd4) return 10;
    return 0;
  endfunction

  // Architectural effect of one operation on HI/LO, in plain 64-bit arithmetic.
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sp, sa, sb, q, r;
    longint unsigned up;
    case (op)
      3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); {hi_m, lo_m} = sp; end
      3'd2: begin up = {32'd0, a} * {32'd0, b}; {hi_m, lo_m} = up; end
      3'd3: if (b != 0) begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        q = sa / sb; r = sa - q * sb;
        lo_m = q[31:0]; hi_m = r[31:0];
      end
      3'd4: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
      3'd5: hi_m = a;
      3'd6: lo_m = a;
      default: ;
    endcase
  endtask

  // Issue one op at cycle T, then walk and check every busy cycle.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic d_md);
    int n = latency(op);
    @(negedge clk);
    md_op = op; rs_val = a; rt_val = b; d_is_md = d_md;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== hi_m || lo !== lo_m)
      $display("[TB] FAIL issue_state: busy=%b hi=%h lo=%h, expected busy=0 hi=%h lo=%h", busy, hi, lo, hi_m, lo_m);
    if (busy !== 1'b0 || hi !== hi_m || lo !== lo_m) failures++;
    checks++;
    if (md_stall !== (d_md && n > 0)) begin
      failures++;
      $display("[TB] FAIL issue_stall: got %b expected %b", md_stall, (d_md && n > 0));
    end
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      md_op = OP_NONE; rs_val = $urandom; rt_val = $urandom;
      #1;
      checks++;
      if (busy !== 1'b1 || hi !== hi_m || lo !== lo_m || md_stall !== d_md) begin
        failures++;
        $display("[TB] FAIL busy_cycle %0d: busy=%b stall=%b hi=%h lo=%h, expected busy=1 stall=%b hi=%h lo=%h",
                 i, busy, md_stall, hi, lo, d_md, hi_m, lo_m);
      end
    end
    model_apply(op, a, b);
  endtask

  task automatic idle_check(input string name);
    @(negedge clk);
    md_op = OP_NONE; rs_val = $urandom; rt_val = $urandom; d_is_md = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || md_stall !== 1'b0 || hi !== hi_m || lo !== lo_m) begin
      failures++;
      $display("[TB] FAIL %s: busy=%b stall=%b hi=%h lo=%h, expected busy=0 stall=0 hi=%h lo=%h",
               name, busy, md_stall, hi, lo, hi_m, lo_m);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; md_op = OP_NONE; rs_val = '0; rt_val = '0; d_is_md = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || md_stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset: hi=%h lo=%h busy=%b stall=%b, expected all 0", hi, lo, busy, md_stall);
    end
  endtask

  task automatic test_mult();
    issue(OP_MULT, 32'hFFFFFFFD, 32'd5, 1'b0);
    idle_check("mult_done");
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
      failures++;
      $display("[TB] FAIL mult_value: hi=%h lo=%h, expected ffffffff fffffff1", hi, lo);
    end
  endtask

  task automatic test_multu_div();
    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0);
    idle_check("multu_done");
    checks++;
    if (hi !== 32'h00000001 || lo !== 32'hFFFFFFFE) begin
      failures++;
      $display("[TB] FAIL multu_value: hi=%h lo=%h, expected 00000001 fffffffe", hi, lo);
    end
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    idle_check("div_done");
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      failures++;
      $display("[TB] FAIL div_value: hi=%h lo=%h, expected ffffffff fffffffd", hi, lo);
    end
  endtask

  task automatic test_move_divzero();
    issue(OP_MTHI, 32'h12345678, $urandom, 1'b0);
    idle_check("mthi");
    issue(OP_MTLO, 32'h9ABCDEF0, $urandom, 1'b0);
    idle_check("mtlo");
    issue(OP_DIVU, 32'd7, 32'd0, 1'b0);
    idle_check("divu_zero");
    checks++;
    if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
      failures++;
      $display("[TB] FAIL divzero_hold: hi=%h lo=%h, expected 12345678 9abcdef0", hi, lo);
    end
  endtask

  task automatic test_div_overflow();
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    idle_check("div_ovf_done");
    checks++;
    if (hi !== 32'h00000000 || lo !== 32'h80000000) begin
      failures++;
      $display("[TB] FAIL div_overflow: hi=%h lo=%h, expected 00000000 80000000", hi, lo);
    end
  endtask

  task automatic test_stall();
    issue(OP_MULT, $urandom, $urandom, 1'b1);
    idle_check("stall_release");
    issue(OP_MULTU, $urandom, $urandom, 1'b0);
    idle_check("no_stall_done");
    issue(3'd7, $urandom, $urandom, 1'b1);
    idle_check("undefined_op");
  endtask

  task automatic test_back_to_back();
    issue(OP_DIV, $urandom, 32'd3, 1'b1);
    issue(OP_MULTU, $urandom, $urandom, 1'b1);
    issue(OP_MTLO, $urandom, $urandom, 1'b1);
    issue(OP_DIVU, $urandom, $urandom_range(1, 100), 1'b1);
    idle_check("b2b_done");
  endtask

  task automatic test_reset_abort();
    issue(OP_MTHI, 32'hCAFEF00D, 32'd0, 1'b0);
    issue(OP_MTLO, 32'h0BADBEEF, 32'd0, 1'b0);
    @(negedge clk);
    md_op = OP_DIV; rs_val = 32'd100; rt_val = 32'd7; d_is_md = 1'b0;
    repeat (2) begin @(negedge clk); md_op = OP_NONE; end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_abort: busy=%b hi=%h lo=%h, expected 0 0 0", busy, hi, lo);
    end
    issue(OP_MULTU, 32'd3, 32'd4, 1'b0);
    idle_check("after_abort");
    checks++;
    if (hi !== 32'd0 || lo !== 32'd12) begin
      failures++;
      $display("[TB] FAIL after_abort_value: hi=%h lo=%h, expected 00000000 0000000c", hi, lo);
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 50)));
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
      issue(op, a, b, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle_check("random_idle");
    end
    idle_check("random_done");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu_div();
    test_move_divzero();
    test_div_overflow();
    test_stall();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
